// File: rtl/spi_top_design.sv
// SPI loopback: internal master m1 serialises a WIDTH-bit word, slave s1 rebuilds it on dout.
// Ports: clk, rst (sync, active high), newd, din[WIDTH] in; dout[WIDTH], done out. Option: SPI_MSB_FIRST_EN.

module spi_master #(
   parameter int WIDTH   = 12,
   parameter int CLK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             newd,
   input  logic [WIDTH-1:0] din,
   output logic             sclk,
   output logic             cs,
   output logic             mosi
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CMAX  = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(WIDTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] data, data_n;
   logic             cs_n, mosi_n;
   logic             rise;
   logic             first_bit, next_bit;

   // Edge at which sclk is about to go 0->1.
   assign rise = (cnt == CMAX) && !sclk;

`ifdef SPI_MSB_FIRST_EN
   assign first_bit = din[WIDTH-1];
   assign next_bit  = data[ILAST - IW'(1) - idx];
`else
   assign first_bit = din[0];
   assign next_bit  = data[idx];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (cnt == CMAX) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         data  <= '0;
         cs    <= 1'b1;
         mosi  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         data  <= data_n;
         cs    <= cs_n;
         mosi  <= mosi_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      data_n  = data;
      cs_n    = cs;
      mosi_n  = mosi;
      if (rise) begin
         unique case (state)
            IDLE: begin
               cs_n = 1'b1;
               if (newd) begin
                  data_n  = din;
                  cs_n    = 1'b0;
                  mosi_n  = first_bit;
                  idx_n   = IW'(1);
                  state_n = SEND;
               end
            end
            SEND: begin
               if (idx == ILAST) begin
                  cs_n    = 1'b1;
                  mosi_n  = 1'b0;
                  idx_n   = '0;
                  state_n = IDLE;
               end else begin
                  mosi_n = next_bit;
                  idx_n  = idx + IW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

module spi_slave #(
   parameter int WIDTH   = 12,
   parameter int CLK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic [WIDTH-1:0] dout,
   output logic             done
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CMAX  = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(WIDTH - 1);

   logic [CW-1:0]    cnt;
   logic [IW-1:0]    bcnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] word;
   logic             rise;

   // Slave tracks the divider phase itself so it samples cs/mosi on the
   // same clk edge as the master's rising strobe, i.e. the values driven
   // one sclk period earlier.
   assign rise = (cnt == CMAX) && !sclk;

`ifdef SPI_MSB_FIRST_EN
   assign word = {sr[WIDTH-2:0], mosi};
`else
   assign word = {mosi, sr[WIDTH-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         bcnt <= '0;
         sr   <= '0;
         dout <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= (cnt == CMAX) ? '0 : cnt + CW'(1);
         if (cs) begin
            bcnt <= '0;
         end else if (rise) begin
            sr <= word;
            if (bcnt == ILAST) begin
               dout <= word;
               done <= 1'b1;
               bcnt <= '0;
            end else begin
               bcnt <= bcnt + IW'(1);
            end
         end
      end
   end
endmodule

module spi_top_design #(
   parameter int WIDTH   = 12,
   parameter int CLK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             newd,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             done
);
   logic sclk;
   logic cs;
   logic mosi;

   spi_master #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) m1 (
      .clk  (clk),
      .rst  (rst),
      .newd (newd),
      .din  (din),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi)
   );

   spi_slave #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) s1 (
      .clk  (clk),
      .rst  (rst),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi),
      .dout (dout),
      .done (done)
   );
endmodule

// File: tb/tb_spi_top_design.sv
// Bench for spi_top_design: scoreboarded loopback words, latency,
// mosi bit order, newd filtering, mid-transfer reset, done width.

module tb_spi_top_design;
   localparam int WIDTH   = 12;
   localparam int CLK_DIV = 10;
   localparam int LAT     = WIDTH * 2 * CLK_DIV;

   logic             clk;
   logic             rst;
   logic             newd;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             done;

   int tests;
   int fails;
   int cyc;
   int done_cnt;
   int long_done;
   logic prev_done;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] got_q[$];
   int               got_t[$];

   spi_top_design dut (
      .clk  (clk),
      .rst  (rst),
      .newd (newd),
      .din  (din),
      .dout (dout),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Records every done pulse with its cycle number.
   always @(negedge clk) begin
      if (done) begin
         got_q.push_back(dout);
         got_t.push_back(cyc);
         done_cnt++;
         if (prev_done) long_done++;
      end
      prev_done = done;
   end

   // Raise newd with word w until a rising strobe accepts it.
   task automatic send(input logic [WIDTH-1:0] w, input bit track,
                       output int acc);
      logic prev;
      bit   ok;
      ok   = 0;
      acc  = 0;
      din  = w;
      newd = 1'b1;
      prev = dut.s1.sclk;
      for (int k = 0; k < 4 * CLK_DIV && !ok; k++) begin
         @(posedge clk);
         #1;
         if (dut.s1.sclk && !prev) begin
            ok  = 1;
            acc = cyc;
         end
         prev = dut.s1.sclk;
      end
      newd = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL accept: no sclk rise seen, want one");
      end
      if (track) exp_q.push_back(w);
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int k = 0; k < budget && got_q.size() < n; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      int k;
      rst  = 1'b1;
      newd = 1'b0;
      din  = '0;
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (dout !== '0) begin
         fails++;
         $display("FAIL reset_dout: got %h want 000", dout);
      end
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      tests++;
      if (dut.cs !== 1'b1) begin
         fails++;
         $display("FAIL reset_cs: got %b want 1", dut.cs);
      end
      tests++;
      if (dut.s1.sclk !== 1'b0) begin
         fails++;
         $display("FAIL reset_sclk: got %b want 0", dut.s1.sclk);
      end
      rst = 1'b0;
      k   = 0;
      for (int i = 1; i <= 50 && k == 0; i++) begin
         @(posedge clk);
         #1;
         if (dut.s1.sclk) k = i;
      end
      tests++;
      if (k != CLK_DIV) begin
         fails++;
         $display("FAIL first_rise: got %0d clks want %0d", k, CLK_DIV);
      end
   endtask

   task automatic test_single;
      logic [WIDTH-1:0] w;
      logic             eb;
      int               acc;
      int               n0;
      w  = 12'hA5C;
      n0 = done_cnt;
      send(w, 1, acc);
      for (int i = 0; i < WIDTH; i++) begin
`ifdef SPI_MSB_FIRST_EN
         eb = w[WIDTH-1-i];
`else
         eb = w[i];
`endif
         tests++;
         if (dut.mosi !== eb || dut.cs !== 1'b0) begin
            fails++;
            $display("FAIL mosi_bit%0d: got %b cs %b want %b cs 0",
                     i, dut.mosi, dut.cs, eb);
         end
         repeat (2 * CLK_DIV) @(posedge clk);
         #1;
      end
      wait_done(1, 3 * LAT);
      tests++;
      if (got_q.size() < 1) begin
         fails++;
         $display("FAIL single_timeout: got no done want 1");
      end else begin
         tests++;
         if (got_q[0] !== exp_q[0]) begin
            fails++;
            $display("FAIL single_dout: got %h want %h", got_q[0], exp_q[0]);
         end
         tests++;
         if (got_t[0] - acc != LAT) begin
            fails++;
            $display("FAIL single_latency: got %0d want %0d",
                     got_t[0] - acc, LAT);
         end
      end
      repeat (3 * CLK_DIV) @(posedge clk);
      tests++;
      if (done_cnt - n0 != 1) begin
         fails++;
         $display("FAIL single_count: got %0d want 1", done_cnt - n0);
      end
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic test_back_to_back;
      int               acc;
      int               n0;
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] e;
      n0 = done_cnt;
      for (int j = 0; j < 2; j++) begin
         w = WIDTH'($urandom);
         send(w, 1, acc);
         wait_done(1, 3 * LAT);
         tests++;
         if (got_q.size() < 1) begin
            fails++;
            $display("FAIL b2b_timeout%0d: got no done want 1", j);
         end else begin
            e = exp_q.pop_front();
            tests++;
            if (got_q[0] !== e) begin
               fails++;
               $display("FAIL b2b_dout%0d: got %h want %h", j, got_q[0], e);
            end
            void'(got_q.pop_front());
            void'(got_t.pop_front());
         end
      end
      repeat (3 * CLK_DIV) @(posedge clk);
      tests++;
      if (done_cnt - n0 != 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d want 2", done_cnt - n0);
      end
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic test_newd_ignored;
      int acc;
      int n0;
      n0 = done_cnt;
      send(12'hFFF, 1, acc);
      din = 12'h000;
      for (int i = 0; i < 25; i++) begin
         repeat (7) @(posedge clk);
         #1;
         newd = 1'b1;
         @(posedge clk);
         #1;
         newd = 1'b0;
      end
      wait_done(1, 3 * LAT);
      repeat (2 * LAT) @(posedge clk);
      #1;
      tests++;
      if (got_q.size() < 1 || got_q[0] !== 12'hFFF) begin
         fails++;
         $display("FAIL ignore_dout: got %h want fff",
                  (got_q.size() > 0) ? got_q[0] : 'x);
      end
      tests++;
      if (done_cnt - n0 != 1) begin
         fails++;
         $display("FAIL ignore_count: got %0d want 1", done_cnt - n0);
      end
      tests++;
      if (dout !== 12'hFFF || dut.cs !== 1'b1) begin
         fails++;
         $display("FAIL ignore_idle: got dout %h cs %b want fff 1",
                  dout, dut.cs);
      end
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic test_reset_mid;
      int acc;
      int n0;
      send(12'h5A5, 0, acc);
      repeat (6 * 2 * CLK_DIV) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n0  = done_cnt;
      repeat (2 * LAT) @(posedge clk);
      #1;
      tests++;
      if (done_cnt != n0) begin
         fails++;
         $display("FAIL abort_done: got %0d pulses want 0", done_cnt - n0);
      end
      tests++;
      if (dout !== '0 || dut.cs !== 1'b1) begin
         fails++;
         $display("FAIL abort_state: got dout %h cs %b want 000 1",
                  dout, dut.cs);
      end
      got_q.delete();
      got_t.delete();
      send(12'h123, 1, acc);
      wait_done(1, 3 * LAT);
      tests++;
      if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
         fails++;
         $display("FAIL after_abort: got %h want 123",
                  (got_q.size() > 0) ? got_q[0] : 'x);
      end
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic test_boundaries;
      int               acc;
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] vals[2];
      vals[0] = 12'h000;
      vals[1] = 12'hFFF;
      for (int j = 0; j < 2; j++) begin
         w = vals[j];
         send(w, 1, acc);
         wait_done(1, 3 * LAT);
         tests++;
         if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            fails++;
            $display("FAIL bound_dout%0d: got %h want %h", j,
                     (got_q.size() > 0) ? got_q[0] : 'x, w);
         end
         repeat (50) @(posedge clk);
         #1;
         tests++;
         if (dout !== w) begin
            fails++;
            $display("FAIL bound_hold%0d: got %h want %h", j, dout, w);
         end
         exp_q.delete();
         got_q.delete();
         got_t.delete();
      end
      tests++;
      if (long_done != 0) begin
         fails++;
         $display("FAIL done_width: got %0d long pulses want 0", long_done);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      done_cnt  = 0;
      long_done = 0;
      prev_done = 1'b0;
      rst       = 1'b1;
      newd      = 1'b0;
      din       = '0;
      test_reset;
      test_single;
      test_back_to_back;
      test_newd_ignored;
      test_reset_mid;
      test_boundaries;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_top_design.md
Name: spi_top_design

Overview:
- Self-contained SPI loopback: an internal SPI master serialises a 12-bit word and an internal SPI slave deserialises it.
- The slave presents the received word on dout and pulses done.
- Used as a top-level wrapper to verify the SPI master/slave pair end to end. No SPI pins leave the block.
- Submodule instances are named m1 (master) and s1 (slave).
- Instance s1 exposes a net named sclk, the serial clock, which benches probe hierarchically as s1.sclk.

Parameters:
- WIDTH, 12: data word width in bits.
- CLK_DIV, 10: clk cycles per sclk half-period. sclk period = 2*CLK_DIV clk cycles (20 by default).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- newd  input  1  new-data request; sampled only in IDLE on an sclk rising strobe.
- din  input  WIDTH  word to transmit; captured together with newd.
- dout  output  WIDTH  last word received by the slave.
- done  output  1  one-clk pulse when dout updates.

Behaviour:
- Single clock domain. sclk, cs and mosi are registers on clk; sclk is never used as a clock.
- Internal nets m1→s1: sclk, cs (active low), mosi. s1 receives sclk as a port of the same name.
- Reset (rst=1 at a clk edge):
  - divider count=0, sclk=0, cs=1, mosi=0;
  - master in IDLE, bit counters=0, shift registers=0;
  - dout=0, done=0.
  - Reset mid-transfer aborts the transfer silently: no done pulse, dout unchanged from 0.
- Divider:
  - counter runs 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and sclk toggles.
  - "Rising strobe" = the clk edge at which sclk goes 0→1.
  - The first rising strobe after reset release occurs CLK_DIV clk cycles later.
- Master FSM (acts only on rising strobes):
  - IDLE: cs=1. If newd=1 at a rising strobe: latch din, drive cs=0, mosi=din[0], bit index=1, go to SEND.
  - SEND: on each rising strobe with index 1..WIDTH-1, drive mosi=din[index] and increment the index. On the strobe with index=WIDTH, drive cs=1 and mosi=0, then return to IDLE.
  - newd is ignored while in SEND.
  - newd held high in IDLE starts a new transfer at the next rising strobe after return to IDLE.
  - Bit order is LSB first.
- Slave s1 (acts on rising strobes):
  - If cs was low before the edge: shift mosi into bit WIDTH-1 of its shift register, shifting the register right, and increment its count.
  - When the WIDTH-th bit is captured: dout ← assembled word, done=1 for exactly one clk cycle, count ← 0.
  - cs high resets the slave count to 0.
- Latency: from the newd-accepting strobe to done = WIDTH sclk periods = 240 clk cycles by default.
- dout holds its value until the next complete word.
- Loopback invariant: dout equals the accepted din after every done.
- newd must be sampled on the strobe edge itself. A bench that raises newd, waits for posedge s1.sclk, then drops newd must get exactly one transfer.

Optional Feature:
- SPI_MSB_FIRST_EN defined:
  - master sends din[WIDTH-1] first, down to din[0];
  - slave shifts left, inserting into bit 0;
  - loopback result and latency unchanged.
- SPI_MSB_FIRST_EN undefined: LSB-first as above.

Test Plan:
- Reset: rst=1 for 5 clks → dout=0, done=0, cs=1, sclk=0. After release, first sclk rise occurs 10 clks later.
- Single word: newd=1, din=12'hA5C; drop newd after posedge s1.sclk → done pulses once, 240 clks after acceptance, dout=12'hA5C; mosi carries bits LSB first.
- Two back-to-back random words (as with $urandom truncated to 12 bits) → each done shows dout==din; exactly two done pulses.
- newd pulsed repeatedly during SEND with din=12'h000 while transferring 12'hFFF → dout=12'hFFF; no extra transfer.
- Reset asserted mid-transfer (after bit 5) → no done pulse, dout=0, cs=1. A subsequent transfer of 12'h123 gives dout=12'h123.
- Boundaries: din=12'h000 and din=12'hFFF → dout matches; done lasts exactly 1 clk.
